// File: rtl/serial_cmd_decoder_if.sv
// Byte receive, byte transmit and single-word memory request bundle.
// The decoder sits on the slave side; the environment drives the master side.
interface serial_cmd_decoder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              cmd_err;
  logic              ovr_err;

  modport master (
    output rx_valid, rx_data, tx_ready, mem_ack, mem_rdata,
    input  tx_valid, tx_data, mem_req, mem_we, mem_addr,
    input  mem_wdata, busy, cmd_err, ovr_err
  );

  modport slave (
    input  rx_valid, rx_data, tx_ready, mem_ack, mem_rdata,
    output tx_valid, tx_data, mem_req, mem_we, mem_addr,
    output mem_wdata, busy, cmd_err, ovr_err
  );
endinterface

// File: rtl/serial_cmd_decoder.sv
// Assembles cmd+payload frames from a byte stream, runs single-word
// memory accesses and streams responses back MSB byte first.
module serial_cmd_decoder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input logic clk,
  input logic reset,
  serial_cmd_decoder_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = 8 * (NB + 1);

  typedef enum logic [1:0] {S_RX, S_MEM, S_TX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, eff_cnt, tx_left_q;
  logic [TW-1:0]     idle_q;
  logic [DATA_W-1:0] sh_q, tx_buf_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, auto_inc_q;
  logic              cmd_err_q, ovr_err_q;

  logic              accept, expired, last_byte, tx_fire;
  logic [FW-1:0]     frame;
  logic [7:0]        cmd;
  logic [DATA_W-1:0] payload, addr_ext, stat_word;

  // Frame view, timeout detection and response word formatting.
  always_comb begin
    accept    = bus.rx_valid && (state_q == S_RX);
    expired   = (cnt_q != '0) && (idle_q == TW'(TIMEOUT));
    eff_cnt   = expired ? '0 : cnt_q;
    last_byte = accept && (eff_cnt == CW'(NB));
    frame     = {sh_q, bus.rx_data};
    cmd       = frame[FW-1 -: 8];
    payload   = frame[DATA_W-1:0];
    tx_fire   = (state_q == S_TX) && bus.tx_ready;
    addr_ext  = '0;
    addr_ext[ADDR_W-1:0] = addr_q;
    stat_word = '0;
    stat_word[DATA_W-1 -: 8] =
      {5'b0, auto_inc_q, ovr_err_q, cmd_err_q};
  end

  // State register; reset aborts any request or response in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RX;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RX: begin
        if (last_byte) begin
          if (cmd == 8'h03 || cmd == 8'h06)
            state_d = S_TX;
          else if (cmd == 8'h04 || cmd == 8'h05)
            state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (bus.mem_ack) state_d = we_q ? S_RX : S_TX;
      end
      S_TX: begin
        if (tx_fire && tx_left_q == CW'(1)) state_d = S_RX;
      end
      default: state_d = S_RX;
    endcase
  end

  // Byte assembly, command registers, memory completion and TX shifting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idle_q     <= '0;
      sh_q       <= '0;
      tx_buf_q   <= '0;
      tx_left_q  <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      auto_inc_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      if (bus.rx_valid && state_q != S_RX) ovr_err_q <= 1'b1;

      if (accept) begin
        idle_q <= '0;
        sh_q   <= frame[DATA_W-1:0];
        cnt_q  <= last_byte ? '0 : eff_cnt + CW'(1);
      end else if (expired) begin
        idle_q <= '0;
        cnt_q  <= '0;
      end else if (cnt_q != '0) begin
        idle_q <= idle_q + TW'(1);
      end

      if (last_byte) begin
        case (cmd)
          8'h01: addr_q <= payload[ADDR_W-1:0];
          8'h02: wdata_q <= payload;
          8'h03: begin
            tx_buf_q  <= addr_ext;
            tx_left_q <= CW'(NB);
          end
          8'h04: we_q <= 1'b1;
          8'h05: we_q <= 1'b0;
          8'h06: begin
            tx_buf_q  <= stat_word;
            tx_left_q <= CW'(1);
          end
          8'h07: auto_inc_q <= payload[0];
          default: cmd_err_q <= 1'b1;
        endcase
      end

      if (state_q == S_MEM && bus.mem_ack) begin
        if (auto_inc_q) addr_q <= addr_q + ADDR_W'(1);
        if (!we_q) begin
          tx_buf_q  <= bus.mem_rdata;
          tx_left_q <= CW'(NB);
        end
      end

      if (tx_fire) begin
        tx_buf_q  <= tx_buf_q << 8;
        tx_left_q <= tx_left_q - CW'(1);
      end
    end
  end

  assign bus.tx_valid  = (state_q == S_TX);
  assign bus.tx_data   = tx_buf_q[DATA_W-1 -: 8];
  assign bus.mem_req   = (state_q == S_MEM);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != S_RX);
  assign bus.cmd_err   = cmd_err_q;
  assign bus.ovr_err   = ovr_err_q;
endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Bench for serial_cmd_decoder: directed table, corner sequences and
// a random byte stream checked against a frame-level reference model.
module tb_serial_cmd_decoder;
  localparam int T   = 16;
  localparam int T16 = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_cmd_decoder_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  serial_cmd_decoder_if #(.DATA_W(16), .ADDR_W(16)) b16 ();

  serial_cmd_decoder #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(T)) dut32 (
    .clk(clk), .reset(reset), .bus(b32.slave)
  );
  serial_cmd_decoder #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(T16)) dut16 (
    .clk(clk), .reset(reset), .bus(b16.slave)
  );

  int n_pass = 0;
  int n_tot  = 0;
  logic [7:0] exq[$];

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] pl;
    logic [31:0] ea;
    logic [31:0] ew;
    logic        eerr;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic sb(input logic [7:0] b);
    b32.rx_valid = 1'b1;
    b32.rx_data  = b;
    @(negedge clk);
    b32.rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] c, input logic [31:0] p);
    sb(c);
    for (int i = 3; i >= 0; i--) sb(p[8*i +: 8]);
  endtask

  task automatic sb16(input logic [7:0] b);
    b16.rx_valid = 1'b1;
    b16.rx_data  = b;
    @(negedge clk);
    b16.rx_valid = 1'b0;
  endtask

  task automatic recv(input string nm, input int stall_i, input int k);
    int w;
    b32.tx_ready = 1'b1;
    for (int i = 0; i < exq.size(); i++) begin
      w = 0;
      while (!b32.tx_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk({nm, " valid"}, b32.tx_valid, 1);
      chk({nm, " byte"}, b32.tx_data, exq[i]);
      if (i == stall_i) begin
        b32.tx_ready = 1'b0;
        repeat (k) begin
          @(negedge clk);
          chk({nm, " hold"}, {b32.tx_valid, b32.tx_data}, {1'b1, exq[i]});
        end
        b32.tx_ready = 1'b1;
      end
      @(negedge clk);
    end
    b32.tx_ready = 1'b0;
    chk({nm, " done"}, {b32.tx_valid, b32.busy}, 0);
    exq.delete();
  endtask

  task automatic mem_serve(input string nm, input int dly, input logic we,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd);
    int w = 0;
    while (!b32.mem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " req"}, {b32.mem_req, b32.mem_we, b32.busy}, {1'b1, we, 1'b1});
    chk({nm, " addr"}, b32.mem_addr, a);
    if (we) chk({nm, " wdata"}, b32.mem_wdata, wd);
    repeat (dly - 1) begin
      @(negedge clk);
      chk({nm, " held"}, {b32.mem_req, b32.mem_we, b32.mem_addr},
          {1'b1, we, a});
    end
    b32.mem_ack   = 1'b1;
    b32.mem_rdata = rd;
    @(negedge clk);
    b32.mem_ack = 1'b0;
    chk({nm, " drop"}, b32.mem_req, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] m_addr, m_wdata, p, rd;
    logic        m_ai, m_cerr;
    logic [7:0]  q[$];
    logic [7:0]  bv;
    int          gap;

    reset = 1'b1;
    b32.rx_valid = 0; b32.rx_data = 0; b32.tx_ready = 0;
    b32.mem_ack = 0; b32.mem_rdata = 0;
    b16.rx_valid = 0; b16.rx_data = 0; b16.tx_ready = 0;
    b16.mem_ack = 0; b16.mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst flags", {b32.tx_valid, b32.mem_req, b32.mem_we, b32.busy,
        b32.cmd_err, b32.ovr_err, b32.tx_data}, 0);
    chk("rst regs", {b32.mem_addr, b32.mem_wdata}, 0);
    reset = 1'b0;
    @(negedge clk);

    frame(8'h01, 32'h44);
    frame(8'h05, 32'h0);
    chk("pre rst req", b32.mem_req, 1);
    #1 reset = 1'b1;
    #1 chk("async rst", {b32.mem_req, b32.busy, b32.tx_valid}, 0);
    chk("async rst addr", b32.mem_addr, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    frame(8'h01, 32'h55);
    chk("post rst addr", {b32.mem_addr, b32.busy}, {32'h55, 1'b0});

    tbl[0] = '{8'h02, 32'hDEADBEEF, 32'h55, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{8'h01, 32'hCAFEF00D, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{8'h07, 32'h0, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{8'h02, 32'h1, 32'hCAFEF00D, 32'h1, 1'b0};
    tbl[4] = '{8'h01, 32'h10, 32'h10, 32'h1, 1'b0};
    tbl[5] = '{8'h02, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, 1'b0};
    for (int i = 0; i < 6; i++) begin
      frame(tbl[i].cmd, tbl[i].pl);
      chk($sformatf("tbl%0d addr", i), b32.mem_addr, tbl[i].ea);
      chk($sformatf("tbl%0d wdata", i), b32.mem_wdata, tbl[i].ew);
      chk($sformatf("tbl%0d err", i), {b32.cmd_err, b32.busy},
          {tbl[i].eerr, 1'b0});
    end

    frame(8'h04, 32'h0);
    mem_serve("wr", 3, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
    chk("wr idle", {b32.busy, b32.mem_addr}, {1'b0, 32'h10});

    frame(8'h07, 32'h1);
    frame(8'h01, 32'hFFFFFFFF);
    frame(8'h05, 32'h0);
    mem_serve("rd", 1, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h12345678);
    exq = '{8'h12, 8'h34, 8'h56, 8'h78};
    recv("rd", 1, 2);
    chk("wrap", b32.mem_addr, 0);
    frame(8'h03, 32'h0);
    exq = '{8'h00, 8'h00, 8'h00, 8'h00};
    recv("getaddr", -1, 0);

    sb(8'h01); sb(8'h11); sb(8'h22);
    repeat (T) @(negedge clk);
    frame(8'h01, 32'hAA);
    chk("timeout", {b32.mem_addr, b32.cmd_err}, {32'hAA, 1'b0});
    sb(8'h01); sb(8'h00); sb(8'h00);
    repeat (T - 1) @(negedge clk);
    sb(8'h00); sb(8'hBB);
    chk("no timeout", {b32.mem_addr, b32.cmd_err}, {32'h000000BB, 1'b0});

    frame(8'h07, 32'h0);
    frame(8'h5A, 32'h0);
    chk("cmd err", {b32.cmd_err, b32.busy, b32.tx_valid}, 3'b100);
    frame(8'h06, 32'h0);
    chk("stat tx", {b32.tx_valid, b32.tx_data}, {1'b1, 8'h01});
    sb(8'hEE);
    chk("ovr", {b32.ovr_err, b32.tx_valid, b32.tx_data}, {2'b11, 8'h01});
    exq = '{8'h01};
    recv("stat1", -1, 0);
    frame(8'h06, 32'h0);
    exq = '{8'h03};
    recv("stat2", -1, 0);

    sb16(8'h01); sb16(8'hBE); sb16(8'hEF);
    chk("w16 addr", b16.mem_addr, 16'hBEEF);
    sb16(8'h03); sb16(8'h00); sb16(8'h00);
    b16.tx_ready = 1'b1;
    chk("w16 b0", {b16.tx_valid, b16.tx_data}, {1'b1, 8'hBE});
    @(negedge clk);
    chk("w16 b1", {b16.tx_valid, b16.tx_data}, {1'b1, 8'hEF});
    @(negedge clk);
    chk("w16 done", {b16.tx_valid, b16.busy}, 0);
    b16.tx_ready = 1'b0;

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_addr = 0; m_wdata = 0; m_ai = 0; m_cerr = 0;
    q.delete();
    for (int n = 0; n < 400; n++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 2, T + 1)
                                        : $urandom_range(0, 2);
      bv = $urandom_range(0, 1) ? 8'($urandom_range(0, 9))
                                : 8'($urandom_range(0, 255));
      repeat (gap) @(negedge clk);
      if (q.size() != 0 && gap >= T) q.delete();
      q.push_back(bv);
      sb(bv);
      if (q.size() == 5) begin
        p = {q[1], q[2], q[3], q[4]};
        case (q[0])
          8'h01: m_addr = p;
          8'h02: m_wdata = p;
          8'h07: m_ai = p[0];
          8'h03: begin
            for (int i = 3; i >= 0; i--) exq.push_back(m_addr[8*i +: 8]);
            recv("r getaddr", $urandom_range(0, 3), $urandom_range(0, 2));
          end
          8'h06: begin
            exq.push_back({5'b0, m_ai, 1'b0, m_cerr});
            recv("r status", 0, $urandom_range(0, 2));
          end
          8'h04: begin
            mem_serve("r wr", $urandom_range(1, 4), 1'b1, m_addr, m_wdata, 0);
            m_addr = m_addr + 32'(m_ai);
          end
          8'h05: begin
            rd = $urandom;
            mem_serve("r rd", $urandom_range(1, 4), 1'b0, m_addr, 0, rd);
            m_addr = m_addr + 32'(m_ai);
            for (int i = 3; i >= 0; i--) exq.push_back(rd[8*i +: 8]);
            recv("r rd", $urandom_range(0, 3), $urandom_range(0, 2));
          end
          default: m_cerr = 1'b1;
        endcase
        q.delete();
        chk("r addr", b32.mem_addr, m_addr);
        chk("r wdata", b32.mem_wdata, m_wdata);
        chk("r flags", {b32.cmd_err, b32.ovr_err, b32.busy}, {m_cerr, 2'b00});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/serial_cmd_decoder.md
Name: serial_cmd_decoder

Overview:
Byte-stream command decoder that assembles fixed-length frames (1 command byte + DATA_W/8 payload bytes, MSB first) from a UART-style byte receiver. It holds address/write-data/mode registers, issues single-word requests to the memory controller (HyperRAM side), and streams responses back as bytes over a ready/valid transmit port. This is the parametrised successor of the 5-byte addr/wdata/start command decoder, adding memory-read return, a handshaked TX path, address auto-increment, an inter-byte timeout and error flags.

Parameters:
DATA_W, 32, payload/memory data width in bits; multiple of 8, 8..64
ADDR_W, 32, address width; ADDR_W <= DATA_W, taken from payload LSBs
TIMEOUT, 1023, idle cycles after which a partial frame is discarded; >= 1

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
tx_valid  out  1  tx_data valid, held until accepted
tx_data  out  8  byte to transmit
tx_ready  in  1  transmitter accepts byte when high with tx_valid
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; stable while mem_req
mem_addr  out  ADDR_W  address register
mem_wdata  out  DATA_W  write-data register
mem_ack  in  1  one-cycle completion; mem_rdata valid this cycle on reads
mem_rdata  in  DATA_W  read data
busy  out  1  high in any state other than RX
cmd_err  out  1  sticky: unknown command received
ovr_err  out  1  sticky: byte arrived while busy (dropped)

Behaviour:
- Reset (async, immediate): all outputs 0, mem_addr/mem_wdata 0, auto-increment off, byte counter 0, state RX. Reset mid-request drops mem_req immediately; any partial frame or TX is discarded.
- NB = DATA_W/8. Byte counter counts 0..NB; a frame is complete when byte NB (the (NB+1)th byte) is accepted; counter then returns to 0.
- Shift register is NB+1 bytes: cmd = first byte, payload = following NB bytes, MSB first.
- Timeout: an idle counter runs only while 0 < count; it clears on each accepted byte. At TIMEOUT idle cycles, count -> 0. If rx_valid coincides with expiry, that byte is taken as byte 0 of a new frame.
- States: RX, MEM, TX.
- RX: accepts bytes. On frame completion the command executes; effects are visible the cycle after the last byte is accepted.
  - 0x01 SET_ADDR: mem_addr <= payload[ADDR_W-1:0]; stay RX.
  - 0x02 SET_WDATA: mem_wdata <= payload; stay RX.
  - 0x03 GET_ADDR: load TX buffer with zero-extended mem_addr, NB bytes; go to TX.
  - 0x04 WRITE: mem_req=1, mem_we=1; go to MEM.
  - 0x05 READ: mem_req=1, mem_we=0; go to MEM.
  - 0x06 STATUS: TX buffer gets 1 byte {5'b0, auto_inc, ovr_err, cmd_err}; go to TX.
  - 0x07 SET_MODE: auto_inc <= payload[0]; stay RX.
  - Any other value: cmd_err <= 1; stay RX; no TX.
- MEM: mem_req, mem_we, mem_addr and mem_wdata are stable until mem_ack. On mem_ack: mem_req <= 0 next cycle; if auto_inc, mem_addr <= mem_addr + 1, wrapping modulo 2^ADDR_W. Write: -> RX. Read: capture mem_rdata into TX buffer (NB bytes) -> TX.
- TX: tx_valid=1 with the MSB byte. A transfer occurs on a rising edge with tx_valid && tx_ready; the next byte is presented the following cycle. tx_ready may stay high for back-to-back bytes, one per cycle. After the last byte is accepted, tx_valid=0 -> RX. tx_data is stable while tx_valid && !tx_ready.
- busy = (state != RX). rx_valid while busy: byte dropped, ovr_err <= 1, byte counter unchanged.
- cmd_err and ovr_err clear only on reset.

Test Plan:
- Reset pulse mid-MEM (mem_req=1) -> mem_req, busy, tx_valid go 0 without a clock edge; next frame decodes normally.
- Frames 01_00000010, 02_DEADBEEF, 04_00000000; mem_ack 3 cycles later -> mem_req held 3 cycles with mem_we=1, addr=0x10, wdata=0xDEADBEEF, then drops; busy returns to 0.
- 07_00000001, 01_FFFFFFFF, 05_00000000; ack with rdata=0x12345678 -> tx bytes 12,34,56,78 with tx_ready stalled 2 cycles on byte 34 (held stable); then 03_00000000 -> tx bytes 00,00,00,00 (address wrapped).
- Send 3 bytes of a frame, idle TIMEOUT cycles, then 01_000000AA -> mem_addr=0xAA, no cmd_err.
- 5A_00000000 then 06_00000000 -> cmd_err=1, status byte 0x01; during that TX send one byte -> ovr_err=1; a following STATUS -> 0x03.
- DATA_W=16, ADDR_W=16: frames of 3 bytes, 01_BEEF then 03_0000 -> tx BE,EF.
